// File: rtl/i2c_pkg.sv
// Shared state encodings, quarter constants and bit counts for the I2C temperature reader.
// Used by i2c_temp_reader and i2c_bit_phase.
package i2c_pkg;

  typedef enum logic [7:0] {
    S_IDLE   = 8'd0,
    S_START  = 8'd1,
    S_WADDR  = 8'd2,
    S_WACK   = 8'd3,
    S_PTR    = 8'd4,
    S_PACK   = 8'd5,
    S_RSTART = 8'd6,
    S_RADDR  = 8'd7,
    S_RACK   = 8'd8,
    S_RD_MSB = 8'd9,
    S_MACK   = 8'd10,
    S_RD_LSB = 8'd11,
    S_MNACK  = 8'd12,
    S_STOP   = 8'd13,
    S_DONE   = 8'd14
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic [3:0] BITS_PER_BYTE = 4'd9;
  localparam logic [3:0] LAST_DATA_BIT = 4'd7;

  // Ninth-bit slots keep the bit index running instead of restarting it.
  function automatic logic is_ack_state(state_e s);
    return s inside {S_WACK, S_PACK, S_RACK, S_MACK, S_MNACK};
  endfunction

  function automatic logic is_slave_ack(state_e s);
    return s inside {S_WACK, S_PACK, S_RACK};
  endfunction

endpackage

// File: rtl/i2c_bit_phase.sv
// Quarter/bit sequencer: four quarters per bit, nine bits per byte, strobes for q2 sample and bit/byte end.
// Defining I2C_CLK_STRETCH_EN holds q2 while the sampled bus SCL is low.
module i2c_bit_phase
  import i2c_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic       scl_i,
  output logic [1:0] qtr_o,
  output logic [3:0] bit_o,
  output logic       sample_o,
  output logic       bit_end_o,
  output logic       byte_end_o
);

  logic [1:0] qtr_q, qtr_d;
  logic [3:0] bit_q, bit_d;
  logic       adv;

`ifdef I2C_CLK_STRETCH_EN
  assign adv = en_i && !((qtr_q == Q2) && !scl_i);
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign adv = en_i;
`endif

  assign qtr_o      = qtr_q;
  assign bit_o      = bit_q;
  assign sample_o   = adv && (qtr_q == Q2);
  assign bit_end_o  = adv && (qtr_q == Q3);
  assign byte_end_o = bit_end_o && (bit_q == BITS_PER_BYTE - 4'd1);

  always_comb begin
    qtr_d = qtr_q;
    bit_d = bit_q;
    if (clr_i) begin
      qtr_d = Q0;
      bit_d = '0;
    end else if (adv) begin
      qtr_d = qtr_q + 2'd1;
      if (qtr_q == Q3) begin
        bit_d = (bit_q == BITS_PER_BYTE - 4'd1) ? 4'd0 : bit_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      qtr_q <= Q0;
      bit_q <= '0;
    end else begin
      qtr_q <= qtr_d;
      bit_q <= bit_d;
    end
  end

endmodule

// File: rtl/i2c_temp_reader.sv
// I2C master: pointer write, repeated start, two-byte read; result held in temperature.
// Optional clock stretching via I2C_CLK_STRETCH_EN (handled in i2c_bit_phase).
module i2c_temp_reader
  import i2c_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              FSM_Clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [7:0]        reg_addr,
  input  logic              SDA_i,
  input  logic              SCL_i,
  output logic              SCL,
  output logic              SDA_o,
  output logic              SDA_oe,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              ACK_bit,
  output logic [7:0]        State,
  output logic [15:0]       temperature
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dev_addr_q, dev_addr_d;
  logic [7:0]        reg_addr_q, reg_addr_d;
  logic              error_q, error_d;
  logic              ack_q, ack_d;
  logic [15:0]       rx_q, rx_d;
  logic [15:0]       temp_q, temp_d;

  logic [1:0] qtr;
  logic [3:0] bit_idx;
  logic       sample, bit_end, byte_end, data_last;
  logic       run, clr;
  logic [7:0] tx_byte, tx_shift;

  assign run       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign clr       = (state_d != state_q) && !is_ack_state(state_d);
  assign data_last = bit_end && (bit_idx == LAST_DATA_BIT);

  i2c_bit_phase u_phase (
    .clk_i      (FSM_Clk),
    .reset_i    (reset),
    .en_i       (run),
    .clr_i      (clr),
    .scl_i      (SCL_i),
    .qtr_o      (qtr),
    .bit_o      (bit_idx),
    .sample_o   (sample),
    .bit_end_o  (bit_end),
    .byte_end_o (byte_end)
  );

  always_ff @(posedge FSM_Clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dev_addr_q <= '0;
      reg_addr_q <= '0;
      error_q    <= 1'b0;
      ack_q      <= 1'b1;
      rx_q       <= '0;
      temp_q     <= '0;
    end else begin
      state_q    <= state_d;
      dev_addr_q <= dev_addr_d;
      reg_addr_q <= reg_addr_d;
      error_q    <= error_d;
      ack_q      <= ack_d;
      rx_q       <= rx_d;
      temp_q     <= temp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dev_addr_d = dev_addr_q;
    reg_addr_d = reg_addr_q;
    error_d    = error_q;
    ack_d      = ack_q;
    rx_d       = rx_q;
    temp_d     = temp_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_START;
          dev_addr_d = dev_addr;
          reg_addr_d = reg_addr;
          error_d    = 1'b0;
        end
      end
      S_START:  if (bit_end)   state_d = S_WADDR;
      S_WADDR:  if (data_last) state_d = S_WACK;
      S_WACK:   if (byte_end)  state_d = ack_q ? S_STOP : S_PTR;
      S_PTR:    if (data_last) state_d = S_PACK;
      S_PACK:   if (byte_end)  state_d = ack_q ? S_STOP : S_RSTART;
      S_RSTART: if (bit_end)   state_d = S_RADDR;
      S_RADDR:  if (data_last) state_d = S_RACK;
      S_RACK:   if (byte_end)  state_d = ack_q ? S_STOP : S_RD_MSB;
      S_RD_MSB: if (data_last) state_d = S_MACK;
      S_MACK:   if (byte_end)  state_d = S_RD_LSB;
      S_RD_LSB: if (data_last) state_d = S_MNACK;
      S_MNACK:  if (byte_end)  state_d = S_STOP;
      S_STOP:   if (bit_end)   state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        if (!error_q) temp_d = rx_q;
      end
      default: state_d = S_IDLE;
    endcase

    // A slave NACK is latched at the q2 sample; the branch to STOP waits for the bit to finish.
    if (sample && is_slave_ack(state_q)) begin
      ack_d   = SDA_i;
      error_d = error_q | SDA_i;
    end
    if (sample && ((state_q == S_RD_MSB) || (state_q == S_RD_LSB))) begin
      rx_d = {rx_q[14:0], SDA_i};
    end
  end

  always_comb begin
    tx_byte = reg_addr_q;
    if (state_q == S_WADDR) tx_byte = 8'({dev_addr_q, 1'b0});
    if (state_q == S_RADDR) tx_byte = 8'({dev_addr_q, 1'b1});
  end

  assign tx_shift = tx_byte << bit_idx;

  always_comb begin
    SCL    = 1'b1;
    SDA_o  = 1'b1;
    SDA_oe = 1'b0;
    case (state_q)
      S_START, S_RSTART: begin
        SDA_oe = 1'b1;
        SDA_o  = (qtr == Q0);
        SCL    = (qtr != Q3);
      end
      S_STOP: begin
        SDA_oe = 1'b1;
        SDA_o  = (qtr == Q3);
        SCL    = (qtr != Q0);
      end
      S_WADDR, S_PTR, S_RADDR: begin
        SDA_oe = 1'b1;
        SDA_o  = tx_shift[7];
        SCL    = qtr[1];
      end
      S_MACK: begin
        SDA_oe = 1'b1;
        SDA_o  = 1'b0;
        SCL    = qtr[1];
      end
      S_MNACK: begin
        SDA_oe = 1'b1;
        SDA_o  = 1'b1;
        SCL    = qtr[1];
      end
      S_WACK, S_PACK, S_RACK, S_RD_MSB, S_RD_LSB: SCL = qtr[1];
      default: ;
    endcase
  end

  assign busy        = run;
  assign done        = (state_q == S_DONE);
  assign error       = error_q;
  assign ACK_bit     = ack_q;
  assign State       = state_q;
  assign temperature = temp_q;

endmodule

// File: tb/tb_i2c_temp_reader.sv
// Self-checking bench: expected bus waveform is composed from START/byte/ACK/STOP segments and compared cycle by cycle.
`timescale 1ns/1ps
module tb_i2c_temp_reader;

  logic        FSM_Clk = 1'b0;
  logic        reset, start, SDA_i, SCL_i, stretch;
  logic [6:0]  dev_addr;
  logic [7:0]  reg_addr;
  logic        SCL, SDA_o, SDA_oe, busy, done, error, ACK_bit;
  logic [7:0]  State;
  logic [15:0] temperature;

  always #5 FSM_Clk = ~FSM_Clk;
  assign SCL_i = SCL & ~stretch;

  i2c_temp_reader #(.ADDR_W(7)) dut (
    .FSM_Clk(FSM_Clk), .reset(reset), .start(start), .dev_addr(dev_addr), .reg_addr(reg_addr),
    .SDA_i(SDA_i), .SCL_i(SCL_i), .SCL(SCL), .SDA_o(SDA_o), .SDA_oe(SDA_oe), .busy(busy),
    .done(done), .error(error), .ACK_bit(ACK_bit), .State(State), .temperature(temperature)
  );

  localparam logic [7:0] ST_IDLE = 8'd0, ST_START = 8'd1, ST_WADDR = 8'd2, ST_WACK = 8'd3;
  localparam logic [7:0] ST_PTR = 8'd4, ST_PACK = 8'd5, ST_RADDR = 8'd7, ST_RACK = 8'd8;
  localparam logic [7:0] ST_RD_MSB = 8'd9, ST_MACK = 8'd10, ST_RD_LSB = 8'd11, ST_MNACK = 8'd12;

  typedef struct packed { logic scl; logic sda; logic oe; logic sdai; } wv_t;
  wv_t wave[$];

  typedef struct {
    string       nm;
    logic [6:0]  dev;
    logic [7:0]  rg;
    logic [2:0]  acks;   // {addr-write, pointer, addr-read}; 1 = slave NACK
    logic [7:0]  msb, lsb;
    logic        err;
    logic [15:0] temp;
    int          lat;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [15:0] model_temp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic scl, input logic sda, input logic oe, input logic sdai);
    wv_t w;
    w.scl = scl; w.sda = sda; w.oe = oe; w.sdai = sdai;
    wave.push_back(w);
  endtask

  task automatic put_cond(input bit is_stop);
    for (int q = 0; q < 4; q++) begin
      if (!is_stop) put(q != 3, q == 0, 1'b1, 1'b1);
      else          put(q != 0, q == 3, 1'b1, 1'b1);
    end
  endtask

  task automatic put_bit(input logic sda, input logic oe, input logic sdai);
    for (int q = 0; q < 4; q++) put(q >= 2, sda, oe, sdai);
  endtask

  task automatic put_tx(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) put_bit(b[i], 1'b1, 1'b1);
  endtask

  task automatic put_rx(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) put_bit(1'b1, 1'b0, b[i]);
  endtask

  task automatic build(input logic [6:0] dev, input logic [7:0] rg, input logic ackw, input logic ackp,
                       input logic ackr, input logic [7:0] msb, input logic [7:0] lsb,
                       input int st_at, input int st_len);
    wave.delete();
    put_cond(1'b0);
    put_tx({dev, 1'b0});
    put_bit(1'b1, 1'b0, ackw);
    if (!ackw) begin
      put_tx(rg);
      put_bit(1'b1, 1'b0, ackp);
      if (!ackp) begin
        put_cond(1'b0);
        put_tx({dev, 1'b1});
        put_bit(1'b1, 1'b0, ackr);
        if (!ackr) begin
          put_rx(msb);
          put_bit(1'b0, 1'b1, 1'b1);
          put_rx(lsb);
          put_bit(1'b1, 1'b1, 1'b1);
        end
      end
    end
    put_cond(1'b1);
    for (int i = 0; i < st_len; i++) wave.insert(st_at, wave[st_at]);
  endtask

  task automatic run_txn(input string nm, input logic [6:0] dev, input logic [7:0] rg,
                         input logic ackw, input logic ackp, input logic ackr,
                         input logic [7:0] msb, input logic [7:0] lsb,
                         input logic exp_err, input logic [15:0] exp_temp, input int exp_lat_in,
                         input int pulse_at, input int abort_at, input bit hold, input int st_at);
    int cyc, lat, wave_bad, exp_lat, nbits, exp_n, slot_bad, extra;
    logic [23:0] txw, exp_w;
    logic prev_scl;
    build(dev, rg, ackw, ackp, ackr, msb, lsb, st_at, (st_at >= 0) ? 10 : 0);
    exp_lat = (exp_lat_in < 0) ? wave.size() : exp_lat_in;
    cyc = 0; lat = -1; wave_bad = -1; nbits = 0; slot_bad = 0; extra = 0;
    txw = '0; prev_scl = 1'b1;

    dev_addr = dev; reg_addr = rg; start = 1'b1; SDA_i = 1'b1;
    @(posedge FSM_Clk); #1;
    if (!hold) start = 1'b0;
    check({nm, "_busy_on_accept"}, busy, 1'b1);

    while (cyc < 400) begin
      if (done) begin lat = cyc; break; end
      if (cyc == abort_at) begin
        reset = 1'b1;
        @(posedge FSM_Clk); #1;
        reset = 1'b0; stretch = 1'b0; SDA_i = 1'b1;
        check({nm, "_rst_scl"}, SCL, 1'b1);
        check({nm, "_rst_oe"}, SDA_oe, 1'b0);
        check({nm, "_rst_state"}, State, ST_IDLE);
        check({nm, "_rst_busy"}, busy, 1'b0);
        check({nm, "_rst_temp"}, temperature, 16'h0);
        check({nm, "_rst_ack"}, ACK_bit, 1'b1);
        return;
      end
      if (cyc < wave.size()) begin
        SDA_i = wave[cyc].sdai;
        if (wave_bad < 0 && (SCL !== wave[cyc].scl || SDA_oe !== wave[cyc].oe ||
                             (wave[cyc].oe && SDA_o !== wave[cyc].sda)))
          wave_bad = cyc;
      end else begin
        SDA_i = 1'b1;
      end
      if (cyc == pulse_at) start = 1'b1;
      else if (!hold) start = 1'b0;
      stretch = (st_at >= 0) && (cyc >= st_at) && (cyc < st_at + 10);
      if (SDA_oe && SCL && !prev_scl && State inside {ST_WADDR, ST_PTR, ST_RADDR}) begin
        txw = {txw[22:0], SDA_o};
        nbits++;
      end
      if (State == ST_MACK && !(SDA_oe && !SDA_o)) slot_bad++;
      if (State == ST_MNACK && !(SDA_oe && SDA_o)) slot_bad++;
      if (State inside {ST_WACK, ST_PACK, ST_RACK, ST_RD_MSB, ST_RD_LSB} && SDA_oe) slot_bad++;
      prev_scl = SCL;
      @(posedge FSM_Clk); #1;
      cyc++;
    end
    stretch = 1'b0;
    SDA_i = 1'b1;

    if (lat < 0) begin
      check({nm, "_done_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({nm, "_done_latency"}, lat, exp_lat);
    check({nm, "_wave_first_bad_cycle"}, wave_bad, -1);
    check({nm, "_busy_at_done"}, busy, 1'b0);
    check({nm, "_error"}, error, exp_err);
    check({nm, "_ack_bit"}, ACK_bit, exp_err);
    check({nm, "_slot_drive"}, slot_bad, 0);
    exp_w = {16'h0, dev, 1'b0}; exp_n = 8;
    if (!ackw) begin exp_w = {exp_w[15:0], rg}; exp_n = 16; end
    if (!ackw && !ackp) begin exp_w = {exp_w[15:0], dev, 1'b1}; exp_n = 24; end
    check({nm, "_tx_bit_count"}, nbits, exp_n);
    check({nm, "_tx_bytes"}, txw, exp_w);

    @(posedge FSM_Clk); #1;
    check({nm, "_done_one_cycle"}, done, 1'b0);
    check({nm, "_state_idle"}, State, ST_IDLE);
    check({nm, "_temperature"}, temperature, exp_temp);

    if (hold) begin
      @(posedge FSM_Clk); #1;
      check({nm, "_retrigger_state"}, State, ST_START);
      check({nm, "_retrigger_busy"}, busy, 1'b1);
      start = 1'b0;
      reset = 1'b1;
      @(posedge FSM_Clk); #1;
      reset = 1'b0;
      check({nm, "_cleanup_state"}, State, ST_IDLE);
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (done || State != ST_IDLE) extra++;
        @(posedge FSM_Clk); #1;
      end
      check({nm, "_no_extra_txn"}, extra, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    logic [6:0] rdev;
    logic [7:0] rrg, rmsb, rlsb;
    logic [2:0] racks;
    int sel;

    tbl[0] = '{nm:"basic",      dev:7'h48, rg:8'h00, acks:3'b000, msb:8'h19, lsb:8'h80, err:1'b0, temp:16'h1980, lat:192};
    tbl[1] = '{nm:"nack_addr",  dev:7'h48, rg:8'h00, acks:3'b100, msb:8'hAA, lsb:8'h55, err:1'b1, temp:16'h1980, lat:44};
    tbl[2] = '{nm:"nack_ptr",   dev:7'h5A, rg:8'h3C, acks:3'b010, msb:8'h00, lsb:8'hFF, err:1'b1, temp:16'h1980, lat:80};
    tbl[3] = '{nm:"nack_raddr", dev:7'h4F, rg:8'h01, acks:3'b001, msb:8'h12, lsb:8'h34, err:1'b1, temp:16'h1980, lat:120};
    tbl[4] = '{nm:"all_ones",   dev:7'h7F, rg:8'hFF, acks:3'b000, msb:8'hA5, lsb:8'h3C, err:1'b0, temp:16'hA53C, lat:192};

    reset = 1'b1; start = 1'b0; SDA_i = 1'b1; stretch = 1'b0; dev_addr = '0; reg_addr = '0;
    repeat (3) @(posedge FSM_Clk);
    #1;
    check("reset_scl", SCL, 1'b1);
    check("reset_sda_o", SDA_o, 1'b1);
    check("reset_sda_oe", SDA_oe, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_error", error, 1'b0);
    check("reset_ack_bit", ACK_bit, 1'b1);
    check("reset_state", State, ST_IDLE);
    check("reset_temperature", temperature, 16'h0);
    reset = 1'b0;
    @(posedge FSM_Clk); #1;

    for (int i = 0; i < 5; i++)
      run_txn(tbl[i].nm, tbl[i].dev, tbl[i].rg, tbl[i].acks[2], tbl[i].acks[1], tbl[i].acks[0],
              tbl[i].msb, tbl[i].lsb, tbl[i].err, tbl[i].temp, tbl[i].lat, -1, -1, 1'b0, -1);

    run_txn("busy_pulse", 7'h48, 8'h01, 1'b0, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0, 16'h1234, 192, 50, -1, 1'b0, -1);
    run_txn("hold_start", 7'h48, 8'h02, 1'b0, 1'b0, 1'b0, 8'hAB, 8'hCD, 1'b0, 16'hABCD, 192, -1, -1, 1'b1, -1);
    run_txn("abort", 7'h48, 8'h00, 1'b0, 1'b0, 1'b0, 8'h77, 8'h66, 1'b0, 16'h0, 192, -1, 100, 1'b0, -1);
    run_txn("after_abort", 7'h48, 8'h00, 1'b0, 1'b0, 1'b0, 8'h19, 8'h80, 1'b0, 16'h1980, 192, -1, -1, 1'b0, -1);
    model_temp = 16'h1980;

    for (int n = 0; n < 8; n++) begin
      rdev = 7'($urandom); rrg = 8'($urandom); rmsb = 8'($urandom); rlsb = 8'($urandom);
      sel = $urandom_range(0, 7);
      racks = (sel == 0) ? 3'b100 : (sel == 1) ? 3'b010 : (sel == 2) ? 3'b001 : 3'b000;
      if (racks == 3'b000) model_temp = {rmsb, rlsb};
      run_txn($sformatf("rand%0d", n), rdev, rrg, racks[2], racks[1], racks[0], rmsb, rlsb,
              racks != 3'b000, model_temp, -1, -1, -1, 1'b0, -1);
    end

`ifdef I2C_CLK_STRETCH_EN
    // PTR starts after START (4) and the address byte (36); bit 3 q2 is 14 cycles further in.
    run_txn("stretch", 7'h48, 8'h00, 1'b0, 1'b0, 1'b0, 8'h19, 8'h80, 1'b0, 16'h1980, 202, -1, -1, 1'b0, 54);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
